uds_tile_feeder: RTL
====================

Name: uds_tile_feeder

Overview:
- Front-end streamer for the upsample/downsample engine.
- Fetches feature-map tiles row by row from a row-wide SRAM and assembles each tile into an A*32-bit word.
- Drives the engine's idata/idata_valid/active/function_mode/scale_factor inputs with the per-tile LOAD/HOLD/GAP sequence the engine requires.
- Started by a host pulse; reports busy/done.

Parameters:
- A, 64, 32-bit items per tile; ROWS = A/8 rows of 8 items (256 bits) each; legal values 64, 32.
- ADDR_W, 10, SRAM row-address width.
- CNT_W, 8, width of tile count.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle start pulse; honoured only in IDLE.
- cfg_base_addr  input  ADDR_W  row address of first row of tile 0.
- cfg_num_tiles  input  CNT_W  number of tiles to stream.
- cfg_function_mode  input  2  engine function_mode (bit1=1 upsample, bit0 max/avg).
- cfg_scale_factor  input  2  engine scale_factor.
- mem_ren  output  1  SRAM read enable.
- mem_addr  output  ADDR_W  SRAM row address.
- mem_rdata  input  256  SRAM read data, valid exactly 1 cycle after mem_ren.
- idata  output  A*32  assembled tile to engine.
- idata_valid  output  1  tile-load strobe to engine.
- active  output  1  engine compute-hold strobe.
- function_mode  output  2  registered mode to engine.
- scale_factor  output  2  registered scale to engine.
- busy  output  1  high from the cycle after start until done.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset: all outputs 0, state IDLE, tile buffer 0, counters 0.
- States: IDLE, FETCH, WAIT, LOAD, HOLD, GAP, DONE. All outputs registered.
- IDLE: on start=1, latch cfg_* into internal regs; function_mode/scale_factor update next cycle. Tile index t=0, row index r=0.
  - If cfg_num_tiles==0, go to DONE (no reads, no strobes).
  - Otherwise go to FETCH.
- FETCH: mem_ren=1, mem_addr=(base + t*ROWS + r) mod 2^ADDR_W, for ROWS consecutive cycles with r=0..ROWS-1; after r=ROWS-1, go to WAIT.
- Capture: data returned for row r is written into idata[r*256 +: 256] one cycle after its read. The last row is captured in WAIT.
- WAIT: mem_ren=0 for 1 cycle, then LOAD.
- LOAD: idata_valid=1, active=0 for 1 cycle. idata holds the complete tile.
- HOLD: idata_valid=0, active=1 for 1 cycle.
- GAP: idata_valid=0, active=0 for 1 cycle (engine emits odata_valid during this window). Then t=t+1, r=0.
  - If t+1 < num_tiles, go to FETCH.
  - Otherwise go to DONE.
- DONE: done=1 for 1 cycle, busy=0, then IDLE.
- Period: per-tile period = ROWS+4 cycles (12 for A=64). Latency from start to first idata_valid = ROWS+2 cycles.
- idata: holds its value outside capture cycles and is never cleared between tiles. Rows are overwritten in place during the next FETCH; the engine samples idata only in LOAD.
- function_mode/scale_factor: held constant for the whole run and keep their value after done until the next accepted start.
- start while busy: ignored; cfg changes while busy are ignored.
- Address wrap: base + t*ROWS + r wraps modulo 2^ADDR_W with no error.
- Reset mid-operation: immediate return to reset values; no done pulse.

Test Plan:
- A=64, base=0x010, num_tiles=1, SRAM row k = {8{k[31:0]}}, start at cycle 0:
  - Expected reads at cycles 1..8, addresses 0x010..0x017.
  - Expected idata_valid at cycle 10, with idata row r = 0x10+r.
  - Expected active at cycle 11, done at cycle 13.
- num_tiles=3, base=0:
  - Expected idata_valid at cycles 10, 22, 34; second tile reads addresses 8..15.
  - Expected exactly 3 active pulses and one done at cycle 37.
- base=0x3FC, num_tiles=1, ADDR_W=10 -> expected read addresses 0x3FC,0x3FD,0x3FE,0x3FF,0x000..0x003, with tile assembled in that order.
- num_tiles=0 -> expected done=1 at cycle 2, with no mem_ren, idata_valid, or active ever asserted.
- Start re-pulsed at cycle 5 with different cfg during a run -> expected no effect on addresses, mode outputs, or timing. Then apply cfg_function_mode=2'b10, scale=1 on a fresh start -> expected outputs show 2'b10/1 from the cycle after start.
- Assert rst_n=0 at cycle 6 of a run -> expected all outputs 0 immediately, no done. Then start after release -> expected normal cycle-1 reads from base.

Source files
------------

// File: rtl/uds_tile_feeder.sv
`default_nettype none
// ============================================================================
// Module   : uds_tile_feeder
// Purpose  : Streams feature-map tiles from a row-wide SRAM into the
//            upsample/downsample engine.  Each tile of A 32-bit items is
//            read as A/8 rows of 256 bits, assembled in place, then offered
//            to the engine through a LOAD / HOLD / GAP strobe sequence.
// Revision : 1.0 - initial release
// ============================================================================
module uds_tile_feeder #(
    parameter int A      = 64,
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   cfg_base_addr,
    input  logic [CNT_W-1:0]    cfg_num_tiles,
    input  logic [1:0]          cfg_function_mode,
    input  logic [1:0]          cfg_scale_factor,
    output logic                mem_ren,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic [255:0]        mem_rdata,
    output logic [A*32-1:0]     idata,
    output logic                idata_valid,
    output logic                active,
    output logic [1:0]          function_mode,
    output logic [1:0]          scale_factor,
    output logic                busy,
    output logic                done
);

    localparam int ROWS = A / 8;
    localparam int R_W  = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_LOAD  = 3'd3,
        S_HOLD  = 3'd4,
        S_GAP   = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t              state_q;
    logic [R_W-1:0]      row_q;
    logic [CNT_W-1:0]    tile_q;
    logic [CNT_W-1:0]    num_tiles_q;
    logic                mem_ren_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic                idata_valid_q;
    logic                active_q;
    logic [1:0]          function_mode_q;
    logic [1:0]          scale_factor_q;
    logic                busy_q;
    logic                done_q;
    logic                cap_q;
    logic [R_W-1:0]      cap_row_q;
    logic [A*32-1:0]     idata_q;
    logic                more_tiles_d;

    // Another tile remains when t+1 < num_tiles (one extra bit avoids overflow).
    always_comb begin
        more_tiles_d = ({1'b0, tile_q} + {{CNT_W{1'b0}}, 1'b1}) < {1'b0, num_tiles_q};
    end

    // Main sequencer: state, counters and every registered engine/SRAM output.
    // The read address simply advances by one per row, since the rows of
    // consecutive tiles are contiguous; wrap happens naturally at 2^ADDR_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            row_q           <= '0;
            tile_q          <= '0;
            num_tiles_q     <= '0;
            mem_ren_q       <= 1'b0;
            mem_addr_q      <= '0;
            idata_valid_q   <= 1'b0;
            active_q        <= 1'b0;
            function_mode_q <= 2'b00;
            scale_factor_q  <= 2'b00;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            mem_ren_q     <= 1'b0;
            idata_valid_q <= 1'b0;
            active_q      <= 1'b0;
            done_q        <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        num_tiles_q     <= cfg_num_tiles;
                        function_mode_q <= cfg_function_mode;
                        scale_factor_q  <= cfg_scale_factor;
                        tile_q          <= '0;
                        row_q           <= '0;
                        busy_q          <= 1'b1;
                        if (cfg_num_tiles == '0) begin
                            // An empty run passes through GAP, which sees no
                            // further tile and finishes one cycle later.
                            state_q <= S_GAP;
                        end else begin
                            state_q    <= S_FETCH;
                            mem_ren_q  <= 1'b1;
                            mem_addr_q <= cfg_base_addr;
                        end
                    end
                end
                S_FETCH: begin
                    if (row_q == R_W'(ROWS - 1)) begin
                        state_q <= S_WAIT;
                        row_q   <= '0;
                    end else begin
                        row_q      <= row_q + R_W'(1);
                        mem_ren_q  <= 1'b1;
                        mem_addr_q <= mem_addr_q + ADDR_W'(1);
                    end
                end
                S_WAIT: begin
                    state_q       <= S_LOAD;
                    idata_valid_q <= 1'b1;
                end
                S_LOAD: begin
                    state_q  <= S_HOLD;
                    active_q <= 1'b1;
                end
                S_HOLD: begin
                    state_q <= S_GAP;
                end
                S_GAP: begin
                    if (more_tiles_d) begin
                        tile_q     <= tile_q + CNT_W'(1);
                        row_q      <= '0;
                        state_q    <= S_FETCH;
                        mem_ren_q  <= 1'b1;
                        mem_addr_q <= mem_addr_q + ADDR_W'(1);
                    end else begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Remember which row was read last cycle so its data lands in the right slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_q     <= 1'b0;
            cap_row_q <= '0;
        end else begin
            cap_q     <= mem_ren_q;
            cap_row_q <= row_q;
        end
    end

    // Tile buffer: rows are overwritten in place; never cleared between tiles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idata_q <= '0;
        end else if (cap_q) begin
            for (int i = 0; i < ROWS; i++) begin
                if (cap_row_q == R_W'(i)) begin
                    idata_q[i*256 +: 256] <= mem_rdata;
                end
            end
        end
    end

    assign mem_ren       = mem_ren_q;
    assign mem_addr      = mem_addr_q;
    assign idata         = idata_q;
    assign idata_valid   = idata_valid_q;
    assign active        = active_q;
    assign function_mode = function_mode_q;
    assign scale_factor  = scale_factor_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule
`default_nettype wire
